// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control encodings for the multicycle RV32I core: opcodes, state codes,
// datapath mux selects and the Moore control word carried by each FSM state.
package multicycle_control_fsm_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_BNE      = 4'd11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       branch_ne;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BR:   return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction function fields onto ALUControl.
module alu_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type has funct7 meaning; addi with imm[10]=1 stays add.
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main controller: Moore FSM sequencing FETCH..WB, ImmSrc decode,
// ALU decoder. Define RV_BNE_EN to add the BNE state (funct3=001 branches).
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    ctrl_t              w_ctrl;

    always_ff @(posedge clk) begin
        if (reset) r_state <= STATE_W'(S_FETCH);
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = STATE_W'(S_FETCH);
        case (r_state)
            S_FETCH: w_state_next = STATE_W'(S_DECODE);
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_state_next = STATE_W'(S_MEMADR);
                    OP_R:         w_state_next = STATE_W'(S_EXECUTER);
                    OP_I:         w_state_next = STATE_W'(S_EXECUTEI);
                    OP_JAL:       w_state_next = STATE_W'(S_JAL);
`ifdef RV_BNE_EN
                    OP_BR: begin
                        if (funct3 == 3'b000)      w_state_next = STATE_W'(S_BEQ);
                        else if (funct3 == 3'b001) w_state_next = STATE_W'(S_BNE);
                        else                       w_state_next = STATE_W'(S_FETCH);
                    end
`else
                    OP_BR:        w_state_next = STATE_W'(S_BEQ);
`endif
                    default:      w_state_next = STATE_W'(S_FETCH);
                endcase
            end
            S_MEMADR:   w_state_next = (op == OP_SW) ? STATE_W'(S_MEMWRITE) : STATE_W'(S_MEMREAD);
            S_MEMREAD:  w_state_next = STATE_W'(S_MEMWB);
            S_EXECUTER: w_state_next = STATE_W'(S_ALUWB);
            S_EXECUTEI: w_state_next = STATE_W'(S_ALUWB);
            S_JAL:      w_state_next = STATE_W'(S_ALUWB);
            default:    w_state_next = STATE_W'(S_FETCH);
        endcase
    end

    // Reset overrides the state so the datapath sees FETCH selects with all writes off.
    always_comb begin
        w_ctrl = '0;
        if (reset) begin
            w_ctrl.alu_src_b  = SRCB_FOUR;
            w_ctrl.result_src = RES_ALURESULT;
        end else begin
            case (r_state)
                S_FETCH: begin
                    w_ctrl.ir_write   = 1'b1;
                    w_ctrl.pc_update  = 1'b1;
                    w_ctrl.alu_src_a  = SRCA_PC;
                    w_ctrl.alu_src_b  = SRCB_FOUR;
                    w_ctrl.result_src = RES_ALURESULT;
                end
                S_DECODE: begin
                    w_ctrl.alu_src_a = SRCA_OLDPC;
                    w_ctrl.alu_src_b = SRCB_IMM;
                end
                S_MEMADR, S_EXECUTEI: begin
                    w_ctrl.alu_src_a = SRCA_RD1;
                    w_ctrl.alu_src_b = SRCB_IMM;
                    w_ctrl.alu_op    = (r_state == STATE_W'(S_EXECUTEI)) ? ALUOP_FUNCT : ALUOP_ADD;
                end
                S_MEMREAD: begin
                    w_ctrl.result_src = RES_ALUOUT;
                    w_ctrl.adr_src    = 1'b1;
                end
                S_MEMWB: begin
                    w_ctrl.result_src = RES_DATA;
                    w_ctrl.reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    w_ctrl.result_src = RES_ALUOUT;
                    w_ctrl.adr_src    = 1'b1;
                    w_ctrl.mem_write  = 1'b1;
                end
                S_EXECUTER: begin
                    w_ctrl.alu_src_a = SRCA_RD1;
                    w_ctrl.alu_src_b = SRCB_RD2;
                    w_ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    w_ctrl.result_src = RES_ALUOUT;
                    w_ctrl.reg_write  = 1'b1;
                end
                S_BEQ: begin
                    w_ctrl.alu_src_a  = SRCA_RD1;
                    w_ctrl.alu_src_b  = SRCB_RD2;
                    w_ctrl.alu_op     = ALUOP_SUB;
                    w_ctrl.result_src = RES_ALUOUT;
                    w_ctrl.branch     = 1'b1;
                end
`ifdef RV_BNE_EN
                S_BNE: begin
                    w_ctrl.alu_src_a  = SRCA_RD1;
                    w_ctrl.alu_src_b  = SRCB_RD2;
                    w_ctrl.alu_op     = ALUOP_SUB;
                    w_ctrl.result_src = RES_ALUOUT;
                    w_ctrl.branch_ne  = 1'b1;
                end
`endif
                S_JAL: begin
                    w_ctrl.alu_src_a  = SRCA_OLDPC;
                    w_ctrl.alu_src_b  = SRCB_FOUR;
                    w_ctrl.result_src = RES_ALUOUT;
                    w_ctrl.pc_update  = 1'b1;
                end
                default: w_ctrl = '0;
            endcase
        end
    end

    assign PCWrite   = w_ctrl.pc_update | (w_ctrl.branch & Zero) | (w_ctrl.branch_ne & ~Zero);
    assign AdrSrc    = w_ctrl.adr_src;
    assign MemWrite  = w_ctrl.mem_write;
    assign IRWrite   = w_ctrl.ir_write;
    assign RegWrite  = w_ctrl.reg_write;
    assign ResultSrc = w_ctrl.result_src;
    assign ALUSrcA   = w_ctrl.alu_src_a;
    assign ALUSrcB   = w_ctrl.alu_src_b;
    assign ImmSrc    = imm_src_of(op);

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_ctrl.alu_op),
        .i_funct3      (funct3),
        .i_op5         (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm; compares a packed control
// word per cycle against hand-computed per-state values.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int n_checks = 0;
    int n_fail   = 0;

    // {PCWrite,AdrSrc,MemWrite,IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, RegWrite}
    wire [13:0] ctrl_v = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                          ALUSrcA, ALUSrcB, ALUControl, RegWrite};

    localparam logic [13:0] V_RESET   = 14'b0000_10_00_10_000_0;
    localparam logic [13:0] V_FETCH   = 14'b1001_10_00_10_000_0;
    localparam logic [13:0] V_DECODE  = 14'b0000_00_01_01_000_0;
    localparam logic [13:0] V_MEMADR  = 14'b0000_00_10_01_000_0;
    localparam logic [13:0] V_MEMREAD = 14'b0100_00_00_00_000_0;
    localparam logic [13:0] V_MEMWB   = 14'b0000_01_00_00_000_1;
    localparam logic [13:0] V_MEMWR   = 14'b0110_00_00_00_000_0;
    localparam logic [13:0] V_ALUWB   = 14'b0000_00_00_00_000_1;
    localparam logic [13:0] V_JAL     = 14'b1000_00_01_10_000_0;

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if (ctrl_v !== V_RESET) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %b want %b", c, ctrl_v, V_RESET);
            end
        end
        reset = 1'b0; #1;
        n_checks++;
        if (ctrl_v !== V_FETCH) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", ctrl_v, V_FETCH);
        end
        n_checks++;
        if ({IRWrite, PCWrite} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_first_fetch IRWrite/PCWrite: got %b want 11", {IRWrite, PCWrite});
        end
        $display("reset: held 3 cycles, released into FETCH");
    endtask

    task automatic test_lw();
        logic [13:0] exp_v [5];
        exp_v = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB};
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; #1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (ctrl_v !== exp_v[c]) begin
                n_fail++;
                $display("FAIL lw cycle %0d: got %b want %b", c + 1, ctrl_v, exp_v[c]);
            end
            if (c == 1) begin
                n_checks++;
                if (ImmSrc !== 2'b00) begin
                    n_fail++;
                    $display("FAIL lw ImmSrc: got %b want 00", ImmSrc);
                end
            end
            @(negedge clk); #1;
        end
        n_checks++;
        if (ctrl_v !== V_FETCH) begin
            n_fail++;
            $display("FAIL lw return: got %b want %b", ctrl_v, V_FETCH);
        end
        $display("lw: 5-cycle sequence checked");
    endtask

    task automatic test_sw();
        logic [13:0] exp_v [4];
        exp_v = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR};
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b1; #1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (ctrl_v !== exp_v[c]) begin
                n_fail++;
                $display("FAIL sw cycle %0d: got %b want %b", c + 1, ctrl_v, exp_v[c]);
            end
            if (c == 1) begin
                n_checks++;
                if (ImmSrc !== 2'b01) begin
                    n_fail++;
                    $display("FAIL sw ImmSrc: got %b want 01", ImmSrc);
                end
            end
            @(negedge clk); #1;
        end
        n_checks++;
        if (ctrl_v !== V_FETCH) begin
            n_fail++;
            $display("FAIL sw return: got %b want %b", ctrl_v, V_FETCH);
        end
        $display("sw: 4-cycle sequence checked");
    endtask

    task automatic test_rtype(input logic [2:0] f3, input logic f7, input logic [2:0] exp_ac);
        logic [13:0] exp_v [4];
        exp_v = '{V_FETCH, V_DECODE, {4'b0000, 2'b00, 2'b10, 2'b00, exp_ac, 1'b0}, V_ALUWB};
        op = 7'b0110011; funct3 = f3; funct7b5 = f7; Zero = 1'b0; #1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (ctrl_v !== exp_v[c]) begin
                n_fail++;
                $display("FAIL rtype f3=%b f7=%b cycle %0d: got %b want %b", f3, f7, c + 1, ctrl_v, exp_v[c]);
            end
            @(negedge clk); #1;
        end
        $display("rtype: funct3=%b funct7b5=%b ALUControl expected %b", f3, f7, exp_ac);
    endtask

    task automatic test_itype(input logic [2:0] f3, input logic f7, input logic [2:0] exp_ac);
        logic [13:0] exp_v [4];
        exp_v = '{V_FETCH, V_DECODE, {4'b0000, 2'b00, 2'b10, 2'b01, exp_ac, 1'b0}, V_ALUWB};
        op = 7'b0010011; funct3 = f3; funct7b5 = f7; Zero = 1'b0; #1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (ctrl_v !== exp_v[c]) begin
                n_fail++;
                $display("FAIL itype f3=%b f7=%b cycle %0d: got %b want %b", f3, f7, c + 1, ctrl_v, exp_v[c]);
            end
            if (c == 1) begin
                n_checks++;
                if (ImmSrc !== 2'b00) begin
                    n_fail++;
                    $display("FAIL itype ImmSrc: got %b want 00", ImmSrc);
                end
            end
            @(negedge clk); #1;
        end
        $display("itype: funct3=%b funct7b5=%b ALUControl expected %b", f3, f7, exp_ac);
    endtask

    task automatic test_branch(input logic [2:0] f3, input logic z, input logic exp_pcw);
        logic [13:0] exp_v [3];
        exp_v = '{V_FETCH, V_DECODE, {exp_pcw, 3'b000, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0}};
        op = 7'b1100011; funct3 = f3; funct7b5 = 1'b0; Zero = z; #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (ctrl_v !== exp_v[c]) begin
                n_fail++;
                $display("FAIL branch f3=%b zero=%b cycle %0d: got %b want %b", f3, z, c + 1, ctrl_v, exp_v[c]);
            end
            if (c == 1) begin
                n_checks++;
                if (ImmSrc !== 2'b10) begin
                    n_fail++;
                    $display("FAIL branch ImmSrc: got %b want 10", ImmSrc);
                end
            end
            if (c == 2) begin
                // Zero feeds PCWrite in the same cycle
                Zero = ~z; #1;
                n_checks++;
                if (PCWrite !== ~exp_pcw) begin
                    n_fail++;
                    $display("FAIL branch zero_toggle f3=%b: got %b want %b", f3, PCWrite, ~exp_pcw);
                end
            end
            @(negedge clk); #1;
        end
        n_checks++;
        if (ctrl_v !== V_FETCH) begin
            n_fail++;
            $display("FAIL branch return: got %b want %b", ctrl_v, V_FETCH);
        end
        $display("branch: funct3=%b zero=%b PCWrite expected %b", f3, z, exp_pcw);
    endtask

    task automatic test_jal();
        logic [13:0] exp_v [5];
        exp_v = '{V_FETCH, V_DECODE, V_JAL, V_ALUWB, V_FETCH};
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; #1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (ctrl_v !== exp_v[c]) begin
                n_fail++;
                $display("FAIL jal cycle %0d: got %b want %b", c + 1, ctrl_v, exp_v[c]);
            end
            if (c == 1) begin
                n_checks++;
                if (ImmSrc !== 2'b11) begin
                    n_fail++;
                    $display("FAIL jal ImmSrc: got %b want 11", ImmSrc);
                end
            end
            if (c < 4) begin
                @(negedge clk); #1;
            end
        end
        $display("jal: 4-cycle sequence checked");
    endtask

    task automatic test_unknown(input logic [6:0] opc, input logic [2:0] f3);
        logic [13:0] exp_v [3];
        exp_v = '{V_FETCH, V_DECODE, V_FETCH};
        op = opc; funct3 = f3; funct7b5 = 1'b0; Zero = 1'b1; #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (ctrl_v !== exp_v[c]) begin
                n_fail++;
                $display("FAIL unknown op=%b f3=%b cycle %0d: got %b want %b", opc, f3, c + 1, ctrl_v, exp_v[c]);
            end
            if (c < 2) begin
                @(negedge clk); #1;
            end
        end
        $display("unknown: op=%b funct3=%b returned to FETCH after DECODE", opc, f3);
    endtask

    task automatic test_reset_midway();
        logic [13:0] exp_v [3];
        exp_v = '{V_FETCH, V_DECODE, V_MEMADR};
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (ctrl_v !== exp_v[c]) begin
                n_fail++;
                $display("FAIL reset_midway cycle %0d: got %b want %b", c + 1, ctrl_v, exp_v[c]);
            end
            if (c < 2) begin
                @(negedge clk); #1;
            end
        end
        reset = 1'b1; #1;
        n_checks++;
        if (ctrl_v !== V_RESET) begin
            n_fail++;
            $display("FAIL reset_midway forced: got %b want %b", ctrl_v, V_RESET);
        end
        @(negedge clk); #1;
        reset = 1'b0; #1;
        n_checks++;
        if (ctrl_v !== V_FETCH) begin
            n_fail++;
            $display("FAIL reset_midway after_edge: got %b want %b", ctrl_v, V_FETCH);
        end
        $display("reset_midway: sw aborted in MEMADR, back in FETCH");
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype(3'b000, 1'b1, 3'b001);
        test_rtype(3'b111, 1'b0, 3'b010);
        test_rtype(3'b010, 1'b0, 3'b101);
        test_rtype(3'b110, 1'b0, 3'b011);
        test_itype(3'b000, 1'b1, 3'b000);
        test_itype(3'b110, 1'b0, 3'b011);
        test_branch(3'b000, 1'b1, 1'b1);
        test_branch(3'b000, 1'b0, 1'b0);
`ifdef RV_BNE_EN
        test_branch(3'b001, 1'b1, 1'b0);
        test_branch(3'b001, 1'b0, 1'b1);
        test_unknown(7'b1100011, 3'b100);
`else
        test_branch(3'b001, 1'b1, 1'b1);
        test_branch(3'b101, 1'b0, 1'b0);
`endif
        test_jal();
        test_unknown(7'b0000000, 3'b000);
        test_lw();
        test_reset_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
